// File: rtl/fp_add_uc.sv
// Sequencing control unit for the single-precision floating-point adder datapath.
// Steps compare/align/add/normalize/round/renormalize and reports result flags.
module fp_add_uc #(
  parameter int unsigned SHIFT_SAT = 26,
  parameter int unsigned FRACT_W   = 27
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         exp_a,
  input  logic [7:0]         exp_b,
  input  logic [7:0]         exp_dif,
  input  logic [FRACT_W-1:0] ula_fract,
  input  logic               round_ovf,
  output logic               sinal_mux_fp1,
  output logic               sinal_mux_fp2,
  output logic               sinal_mux_fp3,
  output logic               sinal_mux_fp4,
  output logic               sinal_mux_fp5,
  output logic [7:0]         sinal_shift_fract,
  output logic [8:0]         sinal_shift_res,
  output logic [8:0]         sinal_inc_or_dec,
  output logic               sinal_round,
  output logic               busy,
  output logic               done,
  output logic               zero_res,
  output logic               exp_overflow,
  output logic               exp_underflow
);

  localparam logic [7:0] SAT8 = 8'(SHIFT_SAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_NORM,
    S_CHECK,
    S_FIX,
    S_DONE
  } state_t;

  state_t     state, state_nx;

  logic       sel_q;
  logic       fp3_q;
  logic [7:0] big_exp_q;
  logic [7:0] shift_fract_q;
  logic [7:0] norm_amt_q;
  logic       zero_q;
  logic       unf_q;
  logic       ovf_q;
  logic       fix_q;

  logic       b_bigger;
  logic [7:0] big_exp;
  logic [7:0] sat_shift;
  logic [7:0] lz;
  logic       found;
  logic [9:0] final_exp;

  assign b_bigger  = (exp_b > exp_a);
  assign big_exp   = b_bigger ? exp_b : exp_a;
  assign sat_shift = (exp_dif > SAT8) ? SAT8 : exp_dif;
  assign final_exp = 10'(big_exp_q) + 10'd1 + {9'd0, fix_q} - {2'd0, norm_amt_q};

  // Leading-zero count from the normalization target bit; stays 0 for a zero sum.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < FRACT_W; i++) begin
      if (!found && ula_fract[FRACT_W-1-i]) begin
        lz    = 8'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sel_q         <= 1'b0;
      fp3_q         <= 1'b0;
      big_exp_q     <= '0;
      shift_fract_q <= '0;
      norm_amt_q    <= '0;
      zero_q        <= 1'b0;
      unf_q         <= 1'b0;
      ovf_q         <= 1'b0;
      fix_q         <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: begin
          sel_q     <= b_bigger;
          fp3_q     <= ~b_bigger;
          big_exp_q <= big_exp;
          zero_q    <= 1'b0;
          unf_q     <= 1'b0;
          ovf_q     <= 1'b0;
          fix_q     <= 1'b0;
        end
        S_ALIGN: begin
          shift_fract_q <= sat_shift;
          zero_q        <= (ula_fract == '0);
          norm_amt_q    <= lz;
          unf_q         <= (lz > big_exp_q);
        end
        S_CHECK: begin
          if (state_nx == S_FIX) fix_q <= 1'b1;
          if (state_nx == S_DONE) ovf_q <= (final_exp >= 10'd255);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx          = state;
    sinal_mux_fp1     = sel_q;
    sinal_mux_fp2     = sel_q;
    sinal_mux_fp3     = fp3_q;
    sinal_mux_fp4     = 1'b0;
    sinal_mux_fp5     = 1'b0;
    sinal_shift_fract = '0;
    sinal_shift_res   = '0;
    sinal_inc_or_dec  = '0;
    sinal_round       = 1'b0;
    busy              = (state != S_IDLE);
    done              = 1'b0;
    zero_res          = zero_q;
    exp_overflow      = ovf_q;
    exp_underflow     = unf_q;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        // Selects must steer the datapath during LOAD itself, before sel_q fills.
        sinal_mux_fp1 = b_bigger;
        sinal_mux_fp2 = b_bigger;
        sinal_mux_fp3 = ~b_bigger;
        state_nx      = S_ALIGN;
      end
      S_ALIGN: begin
        sinal_shift_fract = sat_shift;
        state_nx          = S_NORM;
      end
      S_NORM: begin
        sinal_shift_fract = shift_fract_q;
        sinal_shift_res   = {(norm_amt_q != '0), norm_amt_q};
        sinal_inc_or_dec  = {(norm_amt_q != '0), norm_amt_q};
        sinal_round       = 1'b1;
        state_nx          = S_CHECK;
      end
      S_CHECK: begin
        sinal_shift_fract = shift_fract_q;
        state_nx          = (round_ovf && !fix_q) ? S_FIX : S_DONE;
      end
      S_FIX: begin
        sinal_shift_fract = shift_fract_q;
        sinal_mux_fp4     = 1'b1;
        sinal_mux_fp5     = 1'b1;
        sinal_shift_res   = 9'h001;
        sinal_inc_or_dec  = 9'h001;
        sinal_round       = 1'b1;
        state_nx          = S_CHECK;
      end
      S_DONE: begin
        sinal_shift_fract = shift_fract_q;
        done              = 1'b1;
        state_nx          = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_add_uc.sv
// Bench for fp_add_uc: directed and random operations checked cycle by cycle
// against a reference model derived from the operation's arithmetic.
module tb_fp_add_uc;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  exp_a = '0, exp_b = '0, exp_dif = '0;
  logic [26:0] ula_fract = '0;
  logic        round_ovf = 1'b0;
  logic        fp1, fp2, fp3, fp4, fp5;
  logic [7:0]  shift_fract;
  logic [8:0]  shift_res, inc_or_dec;
  logic        round, busy, done, zero_res, exp_overflow, exp_underflow;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  fp_add_uc #(.SHIFT_SAT(26), .FRACT_W(27)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .exp_a(exp_a), .exp_b(exp_b), .exp_dif(exp_dif),
    .ula_fract(ula_fract), .round_ovf(round_ovf),
    .sinal_mux_fp1(fp1), .sinal_mux_fp2(fp2), .sinal_mux_fp3(fp3),
    .sinal_mux_fp4(fp4), .sinal_mux_fp5(fp5),
    .sinal_shift_fract(shift_fract), .sinal_shift_res(shift_res),
    .sinal_inc_or_dec(inc_or_dec), .sinal_round(round),
    .busy(busy), .done(done), .zero_res(zero_res),
    .exp_overflow(exp_overflow), .exp_underflow(exp_underflow)
  );

  logic [36:0] all_outs;
  assign all_outs = {fp1, fp2, fp3, fp4, fp5, shift_fract, shift_res, inc_or_dec,
                     round, busy, done, zero_res, exp_overflow, exp_underflow};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one operation from the start strobe; checks every cycle up to the IDLE after DONE.
  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ed,
                        input logic [26:0] uf, input bit rov, input bit poke);
    int  big, sat, msb, lz, fexp, ndone;
    bit  bsel, zero, unf, ovf;
    int  v;
    string ph;
    bsel = (eb > ea);
    big  = bsel ? eb : ea;
    sat  = (ed > 26) ? 26 : ed;
    zero = (uf == 0);
    if (zero) lz = 0;
    else begin
      v = uf; msb = 0;
      while (v > 1) begin v = v / 2; msb++; end
      lz = 26 - msb;
    end
    unf   = (lz > big);
    fexp  = (big + 1 + (rov ? 1 : 0) - lz) & 10'h3FF;
    ovf   = (fexp >= 255);
    ndone = rov ? 7 : 5;

    @(posedge clock); #1;
    exp_a = ea; exp_b = eb; exp_dif = ed; ula_fract = uf; round_ovf = rov; start = 1'b1;
    for (int c = 1; c <= ndone + 1; c++) begin
      @(posedge clock); #1;
      start = (poke && c == 2);
      if (c == ndone + 1) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end else begin
        if (c == 1) ph = "load"; else if (c == 2) ph = "align";
        else if (c == 3) ph = "norm"; else if (c == ndone) ph = "done";
        else if (c == 5) ph = "fix"; else ph = "check";
        chk({ph, "_busy"}, busy, 1);
        chk({ph, "_done"}, done, (c == ndone));
        chk({ph, "_sel"}, {fp1, fp2, fp3}, {bsel, bsel, !bsel});
        if (c >= 2) chk({ph, "_shift_fract"}, shift_fract, sat);
        if (ph == "norm") begin
          chk("norm_shift_res", shift_res, (lz > 0) ? (9'h100 | lz) : 0);
          chk("norm_inc_dec", inc_or_dec, (lz > 0) ? (9'h100 | lz) : 0);
          chk("norm_ctl", {fp4, fp5, round}, 3'b001);
        end else if (ph == "fix") begin
          chk("fix_ctl", {fp4, fp5, round}, 3'b111);
          chk("fix_shift_res", shift_res, 9'h001);
          chk("fix_inc_dec", inc_or_dec, 9'h001);
        end else begin
          chk({ph, "_quiet"}, {fp4, fp5, round, shift_res, inc_or_dec}, 0);
        end
        if (ph == "done")
          chk("done_flags", {zero_res, exp_overflow, exp_underflow}, {zero, ovf, unf});
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [26:0] uf;
    int pos;
    repeat (2) @(posedge clock);
    #1 chk("reset_outs", all_outs, 0);
    reset_n = 1'b1;

    run_op(8'h80, 8'h7E, 8'd2,    27'h4000000, 0, 0);
    run_op(8'h70, 8'h90, 8'h20,   27'h4000000, 0, 0);
    run_op(8'h80, 8'h7E, 8'd2,    27'h0080000, 0, 0);
    run_op(8'h05, 8'h03, 8'd2,    27'h0080000, 0, 0);
    run_op(8'h80, 8'h7E, 8'd2,    27'h4000000, 1, 0);
    run_op(8'h40, 8'h41, 8'd1,    27'h0000000, 0, 0);
    run_op(8'hFE, 8'hFE, 8'd0,    27'h4000000, 1, 0);
    run_op(8'hFE, 8'hFE, 8'd0,    27'h4000000, 0, 0);
    run_op(8'h10, 8'h30, 8'h1A,   27'h0000001, 0, 1);

    // Reset asserted mid-operation, in NORM.
    @(posedge clock); #1;
    exp_a = 8'h80; exp_b = 8'h7E; exp_dif = 8'd2; ula_fract = 27'h0080000; round_ovf = 1'b0;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1 chk("reset_in_norm", all_outs, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    run_op(8'h80, 8'h7E, 8'd2, 27'h0080000, 0, 0);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] ea, eb;
      ea  = 8'($urandom);
      eb  = ($urandom_range(0, 3) == 0) ? ea : 8'($urandom);
      pos = $urandom_range(0, 27);
      if (pos == 27) uf = '0;
      else uf = 27'((32'd1 << pos) | ($urandom & ((32'd1 << pos) - 1)));
      run_op(ea, eb, (ea > eb) ? ea - eb : eb - ea, uf, $urandom_range(0, 1) == 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_add_uc.md
Name: fp_add_uc

Overview:
- Control unit for the single-precision floating-point adder datapath (`fd`).
- Accepts a start strobe and drives every datapath select, shift and round control in sequence: exponent compare, fraction alignment, add, normalization, rounding, and post-round renormalization.
- Reads datapath status (exponent difference, raw sum fraction, rounding carry) and flags done, zero, overflow and underflow.

Parameters:
- SHIFT_SAT, 26, maximum alignment shift driven on sinal_shift_fract; larger exp_dif values saturate to this.
- FRACT_W, 27, width of the raw sum fraction field ula_fract.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; operands are stable on the datapath from this cycle until done
- exp_a  in  8  biased exponent of operand A
- exp_b  in  8  biased exponent of operand B
- exp_dif  in  8  registered |exp_a-exp_b| from the datapath; valid one cycle after operands are applied
- ula_fract  in  FRACT_W  sum magnitude from the fraction ALU; bit 26 is the normalization target position
- round_ovf  in  1  datapath rounding carried out of the mantissa (registered round result)
- sinal_mux_fp1  out  1  0 = exp_a is the larger exponent, 1 = exp_b
- sinal_mux_fp2  out  1  bigger-number select, same encoding as fp1
- sinal_mux_fp3  out  1  smaller-number select, always the complement of fp2
- sinal_mux_fp4  out  1  0 = aligned exponent path, 1 = rounded exponent feedback
- sinal_mux_fp5  out  1  0 = ALU fraction, 1 = rounded fraction feedback
- sinal_shift_fract  out  8  right-shift amount for the smaller fraction
- sinal_shift_res  out  9  bit 8 = 1 left / 0 right; bits 7:0 = shift amount
- sinal_inc_or_dec  out  9  bit 8 = 0 add / 1 subtract; bits 7:0 = exponent adjust
- sinal_round  out  1  1 = round register captures the rounded fraction
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse; result on datapath output is valid
- zero_res  out  1  sum was exactly zero; valid with done
- exp_overflow  out  1  final exponent reached or exceeded 255; valid with done
- exp_underflow  out  1  normalization shift exceeded the available exponent; valid with done

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0.
- States: IDLE, LOAD, ALIGN, NORM, CHECK, FIX, DONE.
- IDLE: waits for start. start=1 -> LOAD. start is ignored in every other state.
- LOAD (1 cycle): the exp_dif register fills.
  - Sets fp1 = fp2 = (exp_b > exp_a) and fp3 = ~fp2; these hold until IDLE.
  - Latches big_exp = max(exp_a, exp_b).
  - Equal exponents select A as the bigger operand.
- ALIGN (1 cycle): sinal_shift_fract = min(exp_dif, SHIFT_SAT), held through DONE. On leaving, registers the normalization decision:
  - ula_fract == 0: zero_res=1, shift 0, adjust 0.
  - ula_fract[26] == 1: shift 0, adjust 0.
  - Otherwise lz = count of leading zeros from bit 26 (1..26): left shift lz, subtract lz. exp_underflow = 1 if lz > big_exp.
- NORM (1 cycle): drives fp4=0, fp5=0, the registered shift and adjust, and sinal_round=1. The round register captures at the end of this cycle. Next state CHECK.
- CHECK (1 cycle): examines round_ovf.
  - round_ovf = 1 and FIX not yet visited -> FIX.
  - Otherwise -> DONE.
- FIX (1 cycle): fp4=1, fp5=1, sinal_shift_res = right 1, sinal_inc_or_dec = add 1, sinal_round=1. Next state CHECK. FIX is entered at most once per operation; a second round_ovf is ignored.
- DONE (1 cycle): done=1. exp_overflow = 1 if the final exponent (big_exp + 1 + FIX increment − lz) ≥ 255, computed in 10-bit arithmetic. Next state IDLE.
- Flags hold their value until the next start is accepted and clear in LOAD.
- Latency, start sampled at cycle 0: done at cycle 5 without FIX, cycle 7 with FIX.
- Back-to-back operation: start in the cycle after DONE is accepted. busy drops in the IDLE cycle.
- Outside NORM and FIX, sinal_shift_res, sinal_inc_or_dec and sinal_round are 0.

Test Plan:
- exp_a=0x80, exp_b=0x7E, exp_dif=2, ula_fract bit26=1, round_ovf=0 -> fp1/fp2=0, fp3=1, shift_fract=2, shift_res=0, inc_or_dec=0, done at cycle 5, all flags 0.
- exp_a=0x70, exp_b=0x90, exp_dif=0x20 -> fp1/fp2=1, fp3=0, shift_fract saturates to 26.
- ula_fract=27'h0080000 (leading one at bit 19), big_exp=0x80 -> in NORM shift_res=9'h107, inc_or_dec=9'h107, exp_underflow=0; with big_exp=0x05 -> exp_underflow=1.
- round_ovf=1 in the first CHECK -> FIX asserts fp4=fp5=1, shift_res=9'h001, inc_or_dec=9'h001; done at cycle 7; a held round_ovf does not re-enter FIX.
- ula_fract=0 -> zero_res=1 with done. Exponents 0xFE/0xFE, bit26=1, round_ovf=1 -> exp_overflow=1.
- reset_n low during NORM -> all outputs 0 immediately; a new start after release completes normally. start during busy -> ignored, timing unchanged.
